// File: rtl/ram_rd_stream_pkg.sv
// ram_rd_stream_pkg: state encoding and count-width rule
// shared by the RAM streaming engines.
package ram_rd_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Word counts need one bit above the address to express a full sweep.
  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/ram_rd_stream.sv
// ram_rd_stream: walks a RAM address range and streams words out.
// Optional abort input enabled by RAM_RD_STREAM_ABORT_EN.
module ram_rd_stream
  import ram_rd_stream_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDRWIDTH-1:0]        start_addr,
  input  logic [cnt_w(ADDRWIDTH)-1:0] len,
  output logic                        busy,
  output logic                        done,
  output logic [ADDRWIDTH-1:0]        ram_addr,
  input  logic [DATAWIDTH-1:0]        ram_rd_data,
  output logic [DATAWIDTH-1:0]        out_data,
  output logic                        out_valid,
`ifdef RAM_RD_STREAM_ABORT_EN
  input  logic                        abort,
`endif
  input  logic                        out_ready
);

  localparam int CW = cnt_w(ADDRWIDTH);

  state_t               state_q, state_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]        remain_q, remain_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 fetch;
  logic                 abort_hit;

`ifdef RAM_RD_STREAM_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // A new word is pulled only when the output slot is free or draining.
  assign fetch = (remain_q != '0) && (!valid_q || out_ready);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = start_addr;
          remain_d = len;
          state_d  = (len == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (fetch) begin
          data_d   = ram_rd_data;
          valid_d  = 1'b1;
          addr_d   = addr_q + ADDRWIDTH'(1);
          remain_d = remain_q - CW'(1);
          if (remain_q == CW'(1)) state_d = DRAIN;
        end else if (valid_q && out_ready) begin
          valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (!valid_q || out_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over any handshake in the same cycle.
    if (abort_hit) begin
      valid_d  = 1'b0;
      remain_d = '0;
      done_d   = 1'b1;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign ram_addr  = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_ram_rd_stream.sv
// tb_ram_rd_stream: directed and random transfers against a
// queue-based model of the expected word stream.
module tb_ram_rd_stream;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
`ifdef RAM_RD_STREAM_ABORT_EN
  logic          abort;
`endif

  logic [DW-1:0] mem [DEPTH];
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign ram_rd_data = mem[ram_addr];

  ram_rd_stream #(
    .DATAWIDTH(DW),
    .ADDRWIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .start_addr(start_addr),
    .len(len),
    .busy(busy),
    .done(done),
    .ram_addr(ram_addr),
    .ram_rd_data(ram_rd_data),
    .out_data(out_data),
    .out_valid(out_valid),
`ifdef RAM_RD_STREAM_ABORT_EN
    .abort(abort),
`endif
    .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: always ready, 1: ready 1,0,0 repeating, 2: random
  // ready plus random start strobes while busy.
  task automatic run_xfer(input int sa, input int ln, input int mode);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pd;
    logic [AW-1:0] pa;
    logic stall, rdy;
    int c, done_due, acc, ph;
    for (int i = 0; i < ln; i++) exp_q.push_back(mem[(sa + i) % DEPTH]);
    start = 1'b1;
    start_addr = AW'(sa);
    len = (AW+1)'(ln);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    c = 1;
    done_due = (ln == 0) ? 2 : -1;
    acc = 0;
    ph = 0;
    stall = 1'b0;
    pd = '0;
    pa = '0;
    while (1) begin
      check("busy", busy, (done_due < 0 || c < done_due));
      check("done", done, (c == done_due));
      check("addr", ram_addr, (sa + acc + int'(out_valid)) % DEPTH);
      if (ln == 0) check("no_valid", out_valid, 0);
      if (c == 2 && ln > 0) check("first_beat", out_valid, 1);
      if (stall) begin
        check("stall_data", out_data, pd);
        check("stall_addr", ram_addr, pa);
      end
      if (c == done_due) break;
      if (c > 400) begin
        check("timeout", c, done_due);
        break;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (ph % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ph++;
      out_ready = rdy;
      if (out_valid && rdy) begin
        if (exp_q.size() == 0) check("extra_beat", acc + 1, ln);
        else check("data", out_data, exp_q.pop_front());
        acc++;
        if (acc == ln) done_due = c + 1;
      end
      stall = out_valid && !rdy;
      pd = out_data;
      pa = ram_addr;
      if (mode == 2) begin
        start = 1'($urandom_range(0, 1));
        start_addr = AW'($urandom_range(0, DEPTH - 1));
        len = (AW+1)'($urandom_range(1, DEPTH));
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check("remaining", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    start_addr = '0;
    len = '0;
    out_ready = 1'b0;
`ifdef RAM_RD_STREAM_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 'h10);
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_addr", ram_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    run_xfer(3, 4, 0);
    run_xfer(3, 4, 1);
    run_xfer(14, 4, 0);
    run_xfer(14, 16, 1);
    run_xfer(7, 0, 0);
    run_xfer(9, 16, 2);

    // reset in the middle of a len=8 transfer
    out_ready = 1'b1;
    start_addr = 4'd5;
    len = 5'd8;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_beat1", out_data, mem[5]);
    @(negedge clk);
    check("mid_beat2", out_data, mem[6]);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_valid", out_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_addr", ram_addr, 0);
    check("mid_data", out_data, 0);
    @(negedge clk);
    check("mid_nodone", done, 0);
    run_xfer(1, 5, 0);

`ifdef RAM_RD_STREAM_ABORT_EN
    out_ready = 1'b0;
    start_addr = 4'd2;
    len = 5'd4;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("ab_valid", out_valid, 1);
    check("ab_data", out_data, mem[2]);
    @(negedge clk);
    check("ab_hold", out_data, mem[2]);
    abort = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b0;
    check("ab_vdrop", out_valid, 0);
    check("ab_done", done, 1);
    check("ab_busy", busy, 0);
    @(negedge clk);
    check("ab_done_once", done, 0);
    run_xfer(0, 3, 0);
`endif

    for (int k = 0; k < 6; k++)
      run_xfer($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH), 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_rd_stream.md
# ram_rd_stream

Streaming read engine for the single-port, asynchronous-read inferred RAMs in this library. On a start command it walks a contiguous address range, presents each address on the RAM read port, registers the returned word, and emits it on a valid/ready stream. It is the consumer-side counterpart to the RAM's write path: it unloads buffers filled by a writer into downstream logic at one word per clock while the sink keeps up.

## Interface
- DATAWIDTH, 8, RAM word width and stream data width.
- ADDRWIDTH, 9, RAM address width; depth = 1 << ADDRWIDTH.

- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle command strobe; honoured only in IDLE.
- start_addr  input  ADDRWIDTH  first address read.
- len  input  ADDRWIDTH+1  word count, 0 to 1 << ADDRWIDTH inclusive.
- busy  output  1  high from the cycle after an accepted start until the cycle of done.
- done  output  1  one-cycle pulse at transfer end.
- ram_addr  output  ADDRWIDTH  RAM address; connects to the RAM addr input.
- ram_rd_data  input  DATAWIDTH  RAM combinational read data.
- out_data  output  DATAWIDTH  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready from the sink.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 loads addr_q <= start_addr and remain_q <= len. If len=0, go to DRAIN with nothing to send. Otherwise go to RUN.
- RUN: define fetch = (remain_q != 0) && (!out_valid || out_ready). When fetch=1:
  - out_data <= ram_rd_data, out_valid <= 1.
  - addr_q <= addr_q + 1, truncated to ADDRWIDTH, so the address wraps from the top of the RAM to 0.
  - remain_q <= remain_q - 1.
  - When remain_q reaches 0 after the decrement, go to DRAIN.
- RUN, out_valid && out_ready && !fetch: out_valid <= 0.
- DRAIN: when !out_valid, or out_valid && out_ready, clear out_valid, pulse done, and return to IDLE.
- The engine owns the RAM port while busy. Writers must not assert the RAM write enable while busy=1; this is an integration rule and the block does not check it.
- Once asserted, out_data and out_valid hold stable until accepted.
- start while busy is ignored.
- len = 1 << ADDRWIDTH reads every location exactly once, beginning at start_addr and wrapping.
- ram_addr = addr_q at all times. In IDLE it holds the last value.

## Timing
- Reset state: state=IDLE, addr_q=0, remain_q=0, out_valid=0, out_data=0, busy=0, done=0.
- start sampled at edge N. ram_addr=start_addr during cycle N+1. First out_valid=1 in cycle N+2.
- Throughput: one word per cycle while out_ready=1. When the sink stalls, no address advances and no word is lost.
- Last word accepted at edge M: done=1 and busy=0 in cycle M+1. start is accepted again at edge M+1.
- len=0: done=1 in cycle N+2. out_valid never asserts.
- Reset asserted mid-transfer returns every output to its reset value on the next edge. The in-flight word is discarded and done does not pulse.

## Configuration
- RAM_RD_STREAM_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort=1 in RUN or DRAIN, at any edge, clears out_valid and remain_q, moves to IDLE, and pulses done in the next cycle.
  - abort beats a simultaneous out_ready handshake: the presented word counts as dropped.
  - abort in IDLE is ignored.
- Not defined: no abort port. A transfer always runs to completion or to reset.

## Structure
- Shared package holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
  - The count-width rule ADDRWIDTH+1, shared with the companion writer engines.
- No sub-module. The RAM is instantiated outside this block.
- A bench wrapper pairs this block with ram_sp_async and a simple preload writer.

## Test plan
- Preload mem[i]=i+0x10. start_addr=3, len=4, out_ready=1 -> out_data 0x13,0x14,0x15,0x16 on consecutive cycles starting at N+2; done in the cycle after the last beat.
- Same transfer with out_ready toggling 1,0,0,1,... -> identical sequence; out_data stable on every stalled cycle; ram_addr frozen during stalls.
- ADDRWIDTH=4, start_addr=14, len=4 -> reads addresses 14,15,0,1. len=16 -> all 16 words, each once.
- len=0 -> no out_valid; done pulses exactly once at N+2; busy high for one cycle.
- reset asserted after the second beat of a len=8 transfer -> next cycle out_valid=0, busy=0, no done. A new start then runs cleanly.
- With RAM_RD_STREAM_ABORT_EN: abort during a stalled beat -> out_valid drops, done pulses once, the next start is accepted.
